i2c_byte_ctrl: RTL and testbench
================================

// Module: i2c_byte_ctrl
// PURPOSE
//  Byte-level I2C master sequencer that drives the SCL generator (div/scl_en/scl_beat).
//  Accepts one command per byte: optional START/repeated START, 8 data bits plus ACK, optional STOP.
//  Drives SDA as open-drain (sda_oe=1 pulls low) and gates SCL through scl_en.
//  Times every SDA event from scl_beat using an internal phase counter.
// PARAMETERS
//  DIV_W  32  width of div; must match the SCL generator's div port
// PORTS
//  clk          in   1      system clock
//  rst          in   1      async active-high reset
//  div          in   DIV_W  SCL period in clk cycles; same value as generator; >=8, static while busy
//  scl_beat     in   1      free-running beat from generator (high = first half of period)
//  scl_en       out  1      to generator: 1 lets SCL fall at mid-period; 0 parks SCL high
//  sda_i        in   1      SDA pad input
//  sda_oe       out  1      1 = drive SDA low; 0 = release
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted on valid&ready
//  cmd_start    in   1      precede byte with START (repeated START if bus held)
//  cmd_stop     in   1      follow byte with STOP
//  cmd_read     in   1      1 = read byte, 0 = write byte
//  cmd_wdata    in   8      write byte, MSB first
//  cmd_nack     in   1      read only: 1 = send NACK in the ACK slot
//  rd_data      out  8      last byte read; valid on done
//  ack_n        out  1      write ACK sampled (1 = NACK); valid on done
//  done         out  1      1-clk pulse per completed byte
//  busy         out  1      state != IDLE
//  err_underrun out  1      1-clk pulse when the controller issues an automatic STOP
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE; phase_cnt=0.
//  Events: beat_d<=scl_beat; RISE=scl_beat&~beat_d; phase_cnt<=RISE?0:phase_cnt+1 (saturate).
//   H_MID: phase_cnt==div>>2 (mid SCL-high). L_MID: phase_cnt==(div>>1)+(div>>2) (mid SCL-low).
//  SDA changes only at L_MID, except START/STOP, which change at H_MID. SDA is sampled at H_MID.
//  scl_en changes only at H_MID (set) or RISE (clear), so generator setup holds for div>=8.
//  States:
//   IDLE: cmd_ready=1; on accept latch cmd; START is forced even if cmd_start=0 -> S_WAIT.
//   S_WAIT: at RISE -> S_HI.
//   S_HI: at H_MID: sda_oe<=1, scl_en<=1 -> BIT, bit_cnt=0.
//   BIT (bit_cnt 0..8): at L_MID, drive the slot.
//    - bit_cnt 0..7: write drives sda_oe=~wdata[7-bit_cnt]; read releases SDA.
//    - bit_cnt 8: write releases SDA; read drives sda_oe=~nack.
//    At H_MID: sample sda_i into shift/ack and increment bit_cnt.
//    After H_MID of bit 8: done pulse. Go to STOP_L if stop latched, else to NEXT.
//   NEXT: cmd_ready=1 until a cmd is accepted. At L_MID:
//    - accepted cmd with start: release SDA -> RS_HI.
//    - accepted cmd without start: enter BIT with bit_cnt=0 at this same L_MID.
//    - no cmd: -> STOP_L, pulse err_underrun.
//   RS_HI: at H_MID: sda_oe<=1 (repeated START) -> BIT; bit 0 drives at the following L_MID.
//   STOP_L: at L_MID sda_oe<=1; at next RISE scl_en<=0 -> STOP_H.
//   STOP_H: at H_MID sda_oe<=0 -> IDLE.
//  cmd_ready=0 in all states except IDLE and NEXT. cmd_* inputs are ignored outside a handshake.
//  cmd_stop with IDLE acceptance: byte, then STOP. Clock stretching by the slave is not supported.
//  rst mid-operation: immediately scl_en=0, sda_oe=0, state IDLE. SCL parks high at the
//   generator's next period boundary; no STOP is generated.
// TESTING
//  1 div=400: write 0xA5, start+stop, slave ACKs
//    -> SDA falls at H_MID with SCL high; bits 1010_0101 stable while SCL high.
//    -> done with ack_n=0; STOP rising SDA while SCL high; busy drops.
//  2 Write 0x3C, slave leaves SDA high -> ack_n=1 on done; STOP still issued.
//  3 Read, nack=1, stop=1, slave returns 0x96 -> rd_data=0x96 on done; SDA released in slot 9.
//  4 Write 0xA0 (stop=0); in NEXT, read with start=1, stop=1
//    -> repeated START: SDA low->high at L_MID, high->low at H_MID; read completes, STOP.
//  5 Write with stop=0 and no follow-up cmd
//    -> err_underrun pulse at L_MID after the ACK; STOP sequence; busy=0.
//  6 Assert rst at bit 4 of a write -> next clk: scl_en=0, sda_oe=0, cmd_ready=1, busy=0.

Source files
------------

// File: rtl/i2c_byte_if.sv
// Command and result bundle between a byte producer and the I2C byte sequencer.
interface i2c_byte_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic [7:0] cmd_wdata;
  logic       cmd_nack;
  logic [7:0] rd_data;
  logic       ack_n;
  logic       done;
  logic       busy;
  logic       err_underrun;

  modport master (
    output cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_wdata, cmd_nack,
    input  cmd_ready, rd_data, ack_n, done, busy, err_underrun
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_wdata, cmd_nack,
    output cmd_ready, rd_data, ack_n, done, busy, err_underrun
  );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: START/rSTART, 8 data bits + ACK, STOP,
// with every SDA/SCL-enable event timed from the generator's scl_beat.
module i2c_byte_ctrl #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             scl_beat,
  output logic             scl_en,
  input  logic             sda_i,
  output logic             sda_oe,
  i2c_byte_if.slave        cmd
);

  typedef enum logic [2:0] {
    IDLE, S_WAIT, S_HI, BIT, NEXT, RS_HI, STOP_L, STOP_H
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic [7:0] wdata;
    logic       nack;
  } cmd_t;

  state_t     state, state_nx;
  cmd_t       cmd_q, cmd_q_nx, cmd_in, cmd_eff;
  logic       pending, pending_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] rd_data_q, rd_data_nx;
  logic       ack_n_q, ack_n_nx;
  logic       done_q, done_nx;
  logic       err_q, err_nx;
  logic       sda_oe_nx, scl_en_nx;

  logic             beat_d;
  logic [DIV_W-1:0] phase_cnt;
  logic             rise, h_mid, l_mid, accept;

  // Phase within the SCL period, zeroed on each beat rising edge.
  assign rise  = scl_beat & ~beat_d;
  assign h_mid = (phase_cnt == (div >> 2));
  assign l_mid = (phase_cnt == ((div >> 1) + (div >> 2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_d    <= 1'b0;
      phase_cnt <= '0;
    end else begin
      beat_d <= scl_beat;
      if (rise)
        phase_cnt <= '0;
      else if (phase_cnt != '1)
        phase_cnt <= phase_cnt + DIV_W'(1);
    end
  end

  assign cmd.cmd_ready    = (state == IDLE) || ((state == NEXT) && !pending);
  assign cmd.busy         = (state != IDLE);
  assign cmd.rd_data      = rd_data_q;
  assign cmd.ack_n        = ack_n_q;
  assign cmd.done         = done_q;
  assign cmd.err_underrun = err_q;

  assign accept  = cmd.cmd_valid & cmd.cmd_ready;
  assign cmd_in  = '{start: cmd.cmd_start, stop: cmd.cmd_stop, read: cmd.cmd_read,
                     wdata: cmd.cmd_wdata, nack: cmd.cmd_nack};
  // A command accepted in the very cycle of L_MID is used straight from the bus.
  assign cmd_eff = pending ? cmd_q : cmd_in;

  // SDA pull-down for slot n: data bits for writes, ACK/NACK for reads.
  function automatic logic slot_oe(input cmd_t c, input logic [3:0] n);
    if (n == 4'd8)
      return c.read & ~c.nack;
    return ~c.read & ~c.wdata[3'd7 - n[2:0]];
  endfunction

  always_comb begin
    // NOTE: every target gets a hold default first, so no path can infer a latch.
    state_nx   = state;
    cmd_q_nx   = cmd_q;
    pending_nx = pending;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    rd_data_nx = rd_data_q;
    ack_n_nx   = ack_n_q;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    sda_oe_nx  = sda_oe;
    scl_en_nx  = scl_en;

    unique case (state)
      IDLE: begin
        if (accept) begin
          cmd_q_nx = cmd_in;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise) state_nx = S_HI;
      end
      S_HI: begin
        if (h_mid) begin
          sda_oe_nx  = 1'b1;
          scl_en_nx  = 1'b1;
          bit_cnt_nx = 4'd0;
          state_nx   = BIT;
        end
      end
      BIT: begin
        if (l_mid) sda_oe_nx = slot_oe(cmd_q, bit_cnt);
        if (h_mid) begin
          if (bit_cnt == 4'd8) begin
            done_nx    = 1'b1;
            pending_nx = 1'b0;
            if (cmd_q.read) rd_data_nx = shift;
            else            ack_n_nx   = sda_i;
            state_nx = cmd_q.stop ? STOP_L : NEXT;
          end else begin
            shift_nx   = {shift[6:0], sda_i};
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
      end
      NEXT: begin
        if (accept) begin
          cmd_q_nx   = cmd_in;
          pending_nx = 1'b1;
        end
        if (l_mid) begin
          pending_nx = 1'b0;
          if (pending || accept) begin
            cmd_q_nx = cmd_eff;
            if (cmd_eff.start) begin
              sda_oe_nx = 1'b0;
              state_nx  = RS_HI;
            end else begin
              bit_cnt_nx = 4'd0;
              sda_oe_nx  = slot_oe(cmd_eff, 4'd0);
              state_nx   = BIT;
            end
          end else begin
            // Nothing queued: close the transfer ourselves.
            err_nx    = 1'b1;
            sda_oe_nx = 1'b1;
            state_nx  = STOP_L;
          end
        end
      end
      RS_HI: begin
        if (h_mid) begin
          sda_oe_nx  = 1'b1;
          bit_cnt_nx = 4'd0;
          state_nx   = BIT;
        end
      end
      STOP_L: begin
        if (l_mid) sda_oe_nx = 1'b1;
        if (rise) begin
          scl_en_nx = 1'b0;
          state_nx  = STOP_H;
        end
      end
      STOP_H: begin
        if (h_mid) begin
          sda_oe_nx = 1'b0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      pending   <= 1'b0;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      rd_data_q <= 8'h00;
      ack_n_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sda_oe    <= 1'b0;
      scl_en    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state     <= state_nx;
      cmd_q     <= cmd_q_nx;
      pending   <= pending_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      rd_data_q <= rd_data_nx;
      ack_n_q   <= ack_n_nx;
      done_q    <= done_nx;
      err_q     <= err_nx;
      sda_oe    <= sda_oe_nx;
      scl_en    <= scl_en_nx;
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Directed bench: SCL generator model, bus monitor and simple slave around i2c_byte_ctrl.
module tb_i2c_byte_ctrl;
  localparam int DIV = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] div = 32'(DIV);
  logic        scl_beat, scl_en, sda_i, sda_oe, scl;

  i2c_byte_if bus();

  i2c_byte_ctrl #(.DIV_W(32)) dut (
    .clk(clk), .rst(rst), .div(div), .scl_beat(scl_beat), .scl_en(scl_en),
    .sda_i(sda_i), .sda_oe(sda_oe), .cmd(bus)
  );

  always #5 clk = ~clk;

  // Generator model: free-running period, enable sampled just before mid-period.
  int   gen_cnt  = 0;
  logic gen_en_q = 1'b0;
  always @(posedge clk) begin
    gen_cnt <= (gen_cnt == DIV - 1) ? 0 : gen_cnt + 1;
    if (gen_cnt == DIV / 2 - 1) gen_en_q <= scl_en;
  end
  assign scl_beat = (gen_cnt < DIV / 2);
  assign scl      = gen_en_q ? scl_beat : 1'b1;

  // Slave and monitor state
  logic       slave_drive = 1'b0;
  logic       slave_ack   = 1'b1;
  logic       slave_read  = 1'b0;
  logic [7:0] slave_rdata = 8'h00;
  logic       mode_read = 1'b0, armed = 1'b0;
  int         bitidx = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, hi_event = 1'b0, rise_sda = 1'b1;
  logic [7:0] rx_shift = 8'h00, rx_byte = 8'h00;
  logic       rx_ack = 1'b1;
  int start_cnt = 0, stop_cnt = 0, start_pos = -1, stop_pos = -1;
  int low_rise_pos = -1, rs_rise_pos = -1, unstable_cnt = 0, err_cnt = 0, err_pos = -1;

  assign sda_i = ~(sda_oe | slave_drive);

  always @(negedge clk) begin
    if (bus.err_underrun === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_pos <= gen_cnt;
    end
    if (prev_scl && scl) begin
      if (prev_sda && !sda_i) begin
        start_cnt   <= start_cnt + 1;
        start_pos   <= gen_cnt;
        rs_rise_pos <= low_rise_pos;
        hi_event    <= 1'b1;
        armed       <= 1'b1;
        bitidx      <= 0;
        mode_read   <= slave_read;
        slave_drive <= 1'b0;
      end else if (!prev_sda && sda_i) begin
        stop_cnt    <= stop_cnt + 1;
        stop_pos    <= gen_cnt;
        hi_event    <= 1'b1;
        armed       <= 1'b0;
        slave_drive <= 1'b0;
      end
    end else if (!prev_scl && scl) begin
      rise_sda <= sda_i;
      hi_event <= 1'b0;
      if (armed) begin
        if (bitidx < 8) rx_shift <= {rx_shift[6:0], sda_i};
        else begin
          rx_byte <= rx_shift;
          rx_ack  <= sda_i;
          if (mode_read && sda_i) armed <= 1'b0;
        end
        bitidx <= (bitidx == 8) ? 0 : bitidx + 1;
      end
    end else if (prev_scl && !scl) begin
      if (!hi_event && (sda_i != rise_sda)) unstable_cnt <= unstable_cnt + 1;
      low_rise_pos <= -1;
      if (!armed)         slave_drive <= 1'b0;
      else if (mode_read) slave_drive <= (bitidx < 8) ? !slave_rdata[7 - bitidx] : 1'b0;
      else                slave_drive <= (bitidx == 8) && slave_ack;
    end else if (!scl && !prev_sda && sda_i) begin
      low_rise_pos <= gen_cnt;
    end
    prev_scl <= scl;
    prev_sda <= sda_i;
  end

  int tests_run = 0, tests_failed = 0;

  task automatic send_cmd(input logic s, input logic p, input logic r,
                          input logic [7:0] w, input logic n, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_start = s;
    bus.cmd_stop  = p;
    bus.cmd_read  = r;
    bus.cmd_wdata = w;
    bus.cmd_nack  = n;
    for (int i = 0; i < 8 * DIV; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 15 * DIV; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5 * DIV; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b, want 1/0", bus.cmd_ready, bus.busy);
    end
    tests_run++;
    if (scl_en !== 1'b0 || sda_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pins: scl_en=%b sda_oe=%b, want 0/0", scl_en, sda_oe);
    end
    tests_run++;
    if (bus.done !== 1'b0 || bus.err_underrun !== 1'b0 || bus.ack_n !== 1'b0 || bus.rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_results: done=%b err=%b ack_n=%b rd=%h, want 0/0/0/00",
               bus.done, bus.err_underrun, bus.ack_n, bus.rd_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_ack();
    bit ok;
    int s0, p0;
    slave_ack = 1'b1; slave_read = 1'b0;
    s0 = start_cnt; p0 = stop_cnt;
    send_cmd(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, ok);
    tests_run++;
    if (!ok || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_accept: ok=%b busy=%b ready=%b, want 1/1/0", ok, bus.busy, bus.cmd_ready);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || bus.ack_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_done_ack: seen=%b ack_n=%b, want 1/0", ok, bus.ack_n);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wr_idle: busy=%b, want 0", bus.busy);
    end
    tests_run++;
    if (start_cnt != s0 + 1 || start_pos != DIV / 4 + 2) begin
      tests_failed++;
      $display("FAIL wr_start: count=%0d pos=%0d, want %0d/%0d", start_cnt - s0, start_pos, 1, DIV / 4 + 2);
    end
    tests_run++;
    if (rx_byte !== 8'hA5 || unstable_cnt != 0) begin
      tests_failed++;
      $display("FAIL wr_bits: byte=%h unstable=%0d, want a5/0", rx_byte, unstable_cnt);
    end
    tests_run++;
    if (stop_cnt != p0 + 1 || stop_pos != DIV / 4 + 2 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL wr_stop: count=%0d pos=%0d err=%0d, want 1/%0d/0", stop_cnt - p0, stop_pos, err_cnt, DIV / 4 + 2);
    end
  endtask

  task automatic test_write_nack();
    bit ok;
    int p0;
    slave_ack = 1'b0; slave_read = 1'b0;
    p0 = stop_cnt;
    send_cmd(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, ok);
    wait_done(ok);
    tests_run++;
    if (!ok || bus.ack_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL nack_done: seen=%b ack_n=%b, want 1/1", ok, bus.ack_n);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || stop_cnt != p0 + 1 || rx_byte !== 8'h3C) begin
      tests_failed++;
      $display("FAIL nack_stop: idle=%b stops=%0d byte=%h, want 1/1/3c", ok, stop_cnt - p0, rx_byte);
    end
    slave_ack = 1'b1;
  endtask

  task automatic test_read_nack();
    bit ok;
    int p0;
    slave_read = 1'b1; slave_rdata = 8'h96;
    p0 = stop_cnt;
    send_cmd(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, ok);
    wait_done(ok);
    tests_run++;
    if (!ok || bus.rd_data !== 8'h96) begin
      tests_failed++;
      $display("FAIL rd_data: seen=%b rd=%h, want 1/96", ok, bus.rd_data);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || rx_ack !== 1'b1 || stop_cnt != p0 + 1 || unstable_cnt != 0) begin
      tests_failed++;
      $display("FAIL rd_slot9: idle=%b ack_slot=%b stops=%0d unstable=%0d, want 1/1/1/0",
               ok, rx_ack, stop_cnt - p0, unstable_cnt);
    end
    slave_read = 1'b0;
  endtask

  task automatic test_repeated_start();
    bit ok;
    int s0, p0;
    slave_ack = 1'b1; slave_read = 1'b0; slave_rdata = 8'h5A;
    s0 = start_cnt; p0 = stop_cnt;
    send_cmd(1'b1, 1'b0, 1'b0, 8'hA0, 1'b0, ok);
    wait_done(ok);
    tests_run++;
    if (!ok || bus.ack_n !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rs_first: seen=%b ack_n=%b busy=%b, want 1/0/1", ok, bus.ack_n, bus.busy);
    end
    slave_read = 1'b1;
    send_cmd(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rs_accept: accepted=%b, want 1", ok);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || bus.rd_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL rs_read: seen=%b rd=%h, want 1/5a", ok, bus.rd_data);
    end
    wait_idle(ok);
    tests_run++;
    if (start_cnt != s0 + 2 || start_pos != DIV / 4 + 2 || rs_rise_pos < DIV / 2 || rs_rise_pos >= DIV) begin
      tests_failed++;
      $display("FAIL rs_timing: starts=%0d fall_pos=%0d rise_pos=%0d, want 2/%0d/low half",
               start_cnt - s0, start_pos, rs_rise_pos, DIV / 4 + 2);
    end
    tests_run++;
    if (!ok || stop_cnt != p0 + 1 || unstable_cnt != 0) begin
      tests_failed++;
      $display("FAIL rs_stop: idle=%b stops=%0d unstable=%0d, want 1/1/0", ok, stop_cnt - p0, unstable_cnt);
    end
    slave_read = 1'b0;
  endtask

  task automatic test_underrun();
    bit ok;
    int p0, e0;
    slave_ack = 1'b1; slave_read = 1'b0;
    p0 = stop_cnt; e0 = err_cnt;
    send_cmd(1'b1, 1'b0, 1'b0, 8'h5B, 1'b0, ok);
    wait_done(ok);
    tests_run++;
    if (!ok || bus.err_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL ur_done: seen=%b err=%b, want 1/0", ok, bus.err_underrun);
    end
    wait_idle(ok);
    tests_run++;
    if (err_cnt != e0 + 1 || err_pos != DIV / 2 + DIV / 4 + 2) begin
      tests_failed++;
      $display("FAIL ur_pulse: pulses=%0d pos=%0d, want 1/%0d", err_cnt - e0, err_pos, DIV / 2 + DIV / 4 + 2);
    end
    tests_run++;
    if (!ok || stop_cnt != p0 + 1) begin
      tests_failed++;
      $display("FAIL ur_stop: idle=%b stops=%0d, want 1/1", ok, stop_cnt - p0);
    end
  endtask

  task automatic test_reset_midbyte();
    bit ok, hit;
    slave_ack = 1'b1; slave_read = 1'b0;
    send_cmd(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0, ok);
    hit = 1'b0;
    for (int i = 0; i < 10 * DIV; i++) begin
      @(posedge clk);
      if (armed && bitidx == 4) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL mid_reach_bit4: reached=%b, want 1", hit);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (scl_en !== 1'b0 || sda_oe !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: scl_en=%b sda_oe=%b ready=%b busy=%b, want 0/0/1/0",
               scl_en, sda_oe, bus.cmd_ready, bus.busy);
    end
    repeat (2 * DIV) @(negedge clk);
    tests_run++;
    if (scl !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_scl_park: scl=%b, want 1", scl);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_read  = 1'b0;
    bus.cmd_wdata = 8'h00;
    bus.cmd_nack  = 1'b0;
    test_reset();
    test_write_ack();
    test_write_nack();
    test_read_nack();
    test_repeated_start();
    test_underrun();
    test_reset_midbyte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
